// File: rtl/c17_pipe.sv
// c17_pipe: LANES-wide ISCAS-85 c17 datapath with input/output ranks and optional cuts after NAND levels 1 and 2.
// Defining C17_PIPE_CNT_EN adds a saturating 16-bit out_count of emitted valid beats.
module c17_pipe #(
  parameter int LANES = 4,
  parameter int CUT1  = 1,
  parameter int CUT2  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [LANES-1:0] N1,
  input  logic [LANES-1:0] N2,
  input  logic [LANES-1:0] N3,
  input  logic [LANES-1:0] N6,
  input  logic [LANES-1:0] N7,
  output logic             out_valid,
  output logic [LANES-1:0] N22,
  output logic [LANES-1:0] N23
`ifdef C17_PIPE_CNT_EN
  ,
  output logic [15:0]      out_count
`endif
);
  logic [LANES-1:0] i1_q, i2_q, i3_q, i6_q, i7_q, i1_d, i2_d, i3_d, i6_d, i7_d;
  logic [LANES-1:0] a10_q, a11_q, a2_q, a7_q, a10_d, a11_d, a2_d, a7_d;
  logic [LANES-1:0] b10_q, b16_q, b19_q, b10_d, b16_d, b19_d;
  logic [LANES-1:0] n22_q, n23_q, n22_d, n23_d;
  logic [LANES-1:0] n10, n11, n16, n19, s10, s11, s2, s7, t10, t16, t19;
  logic [3:0]       v_q, v_d;
  logic             sv, tv;
  // A disabled cut selects the combinational value, leaving its rank unloaded-from and optimised away.
  always_comb begin
    n10   = ~(i1_q & i3_q);
    n11   = ~(i3_q & i6_q);
    s10   = (CUT1 != 0) ? a10_q : n10;
    s11   = (CUT1 != 0) ? a11_q : n11;
    s2    = (CUT1 != 0) ? a2_q : i2_q;
    s7    = (CUT1 != 0) ? a7_q : i7_q;
    sv    = (CUT1 != 0) ? v_q[1] : v_q[0];
    n16   = ~(s2 & s11);
    n19   = ~(s11 & s7);
    t10   = (CUT2 != 0) ? b10_q : s10;
    t16   = (CUT2 != 0) ? b16_q : n16;
    t19   = (CUT2 != 0) ? b19_q : n19;
    tv    = (CUT2 != 0) ? v_q[2] : sv;
    i1_d  = en ? N1 : i1_q;
    i2_d  = en ? N2 : i2_q;
    i3_d  = en ? N3 : i3_q;
    i6_d  = en ? N6 : i6_q;
    i7_d  = en ? N7 : i7_q;
    a10_d = en ? n10 : a10_q;
    a11_d = en ? n11 : a11_q;
    a2_d  = en ? i2_q : a2_q;
    a7_d  = en ? i7_q : a7_q;
    b10_d = en ? s10 : b10_q;
    b16_d = en ? n16 : b16_q;
    b19_d = en ? n19 : b19_q;
    n22_d = en ? ~(t10 & t16) : n22_q;
    n23_d = en ? ~(t16 & t19) : n23_q;
    v_d   = en ? {tv, sv, v_q[0], in_valid} : v_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {i1_q, i2_q, i3_q, i6_q, i7_q} <= '0;
      {a10_q, a11_q, a2_q, a7_q}     <= '0;
      {b10_q, b16_q, b19_q}          <= '0;
      {n22_q, n23_q}                 <= '0;
      v_q                            <= '0;
    end else begin
      {i1_q, i2_q, i3_q, i6_q, i7_q} <= {i1_d, i2_d, i3_d, i6_d, i7_d};
      {a10_q, a11_q, a2_q, a7_q}     <= {a10_d, a11_d, a2_d, a7_d};
      {b10_q, b16_q, b19_q}          <= {b10_d, b16_d, b19_d};
      {n22_q, n23_q}                 <= {n22_d, n23_d};
      v_q                            <= v_d;
    end
  assign N22       = n22_q;
  assign N23       = n23_q;
  assign out_valid = v_q[3];
`ifdef C17_PIPE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (en && tv && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign out_count = cnt_q;
`endif
endmodule
